// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: the one-hot ALU opcode set, the issue
// request record and the requester count.
package alu_arbiter_pkg;

  localparam int ALU_ARB_NUM_REQ = 2;

  typedef enum logic [7:0] {
    ALU_NOP   = 8'h00,
    ALU_ADD   = 8'h01,
    ALU_SUB   = 8'h02,
    ALU_AND   = 8'h04,
    ALU_OR    = 8'h08,
    ALU_XOR   = 8'h10,
    ALU_SLT   = 8'h20,
    ALU_SLTU  = 8'h40,
    ALU_SLT_B = 8'h80
  } InstructionSetALU;

  typedef struct packed {
    InstructionSetALU op;
    logic [31:0]      in1;
    logic [31:0]      in2;
  } alu_req_t;

  localparam alu_req_t ALU_REQ_IDLE = '{op: ALU_NOP, in1: 32'h0000_0000, in2: 32'h0000_0000};

  // Index of the single set bit of a two-requester one-hot grant.
  function automatic logic grant_id(input logic [ALU_ARB_NUM_REQ-1:0] g);
    return g[1] & ~g[0];
  endfunction

endpackage

// File: rtl/alu_arbiter_grant.sv
// Grant selection for the two ALU requesters. Policy is fixed priority to
// requester 0 unless ALU_ARBITER_ROUND_ROBIN_EN is defined (round robin).
module alu_arbiter_grant
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_ARB_NUM_REQ-1:0] req_valid,
  input  logic                       can_accept,
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  input  logic                       last_grant,
`endif
  output logic [ALU_ARB_NUM_REQ-1:0] grant
);

  logic [ALU_ARB_NUM_REQ-1:0] win_s;

  // Pick the winner among the requesters currently presenting a request
  always_comb begin
    win_s = 2'b00;
    case (req_valid)
      2'b01:   win_s = 2'b01;
      2'b10:   win_s = 2'b10;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
      2'b11:   win_s = last_grant ? 2'b01 : 2'b10;
`else
      2'b11:   win_s = 2'b01;
`endif
      default: win_s = 2'b00;
    endcase
  end

  assign grant = win_s & {ALU_ARB_NUM_REQ{can_accept}};

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: issue register S1 drives the ALU,
// result register S2 returns the answer. ALU_ARBITER_ROUND_ROBIN_EN selects
// round-robin arbitration (default: fixed priority to requester 0).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ALU_ARB_NUM_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  InstructionSetALU   req_op  [NUM_REQ],
  input  logic [31:0]        req_in1 [NUM_REQ],
  input  logic [31:0]        req_in2 [NUM_REQ],
  output logic [NUM_REQ-1:0] rsp_valid,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_flag,
  output InstructionSetALU   alu_op,
  output logic [31:0]        alu_in1,
  output logic [31:0]        alu_in2,
  output logic [31:0]        alu_in1_b,
  output logic [31:0]        alu_in2_b,
  input  logic [31:0]        alu_out,
  input  logic               alu_out_b
);

  logic         s1_valid_r;
  logic         s1_id_r;
  alu_req_t     s1_req_r;
  logic         s2_valid_r;
  logic         s2_id_r;
  logic [31:0]  s2_data_r;
  logic         s2_flag_r;

  logic               s2_free_s;
  logic               s1_adv_s;
  logic               can_accept_s;
  logic               accept_s;
  logic               accept_id_s;
  logic [NUM_REQ-1:0] grant_s;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic last_grant_r;
`endif

  assign s2_free_s    = !s2_valid_r || rsp_ready[s2_id_r];
  assign s1_adv_s     = s1_valid_r && s2_free_s;
  assign can_accept_s = !s1_valid_r || s1_adv_s;

  alu_arbiter_grant u_grant (
    .req_valid  (req_valid),
    .can_accept (can_accept_s),
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    .last_grant (last_grant_r),
`endif
    .grant      (grant_s)
  );

  // Nothing is offered while reset is held, even if stale state would allow it
  assign req_ready   = reset ? {NUM_REQ{1'b0}} : (grant_s & {NUM_REQ{can_accept_s}});
  assign accept_s    = |(req_ready & req_valid);
  assign accept_id_s = grant_id(req_ready);

  // Issue stage: load on accept, empty (and idle the ALU) when it drains
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_id_r    <= 1'b0;
      s1_req_r   <= ALU_REQ_IDLE;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_id_r    <= accept_id_s;
      s1_req_r   <= '{op: req_op[accept_id_s], in1: req_in1[accept_id_s], in2: req_in2[accept_id_s]};
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
      s1_id_r    <= 1'b0;
      s1_req_r   <= ALU_REQ_IDLE;
    end
  end

  // Result stage: capture ALU output on advance, clear once consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_id_r    <= 1'b0;
      s2_data_r  <= 32'h0000_0000;
      s2_flag_r  <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_id_r    <= s1_id_r;
      s2_data_r  <= alu_out;
      s2_flag_r  <= alu_out_b;
    end else if (s2_valid_r && rsp_ready[s2_id_r]) begin
      s2_valid_r <= 1'b0;
      s2_id_r    <= 1'b0;
      s2_data_r  <= 32'h0000_0000;
      s2_flag_r  <= 1'b0;
    end
  end

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  // Remember who was served last so the other requester wins the next tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      last_grant_r <= accept_id_s;
    end
  end
`endif

  // Steer the shared result bus qualifier to the owning requester
  always_comb begin
    rsp_valid = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = s2_valid_r && (s2_id_r == 1'(i));
    end
  end

  assign rsp_data  = s2_data_r;
  assign rsp_flag  = s2_flag_r;
  assign alu_op    = s1_req_r.op;
  assign alu_in1   = s1_req_r.in1;
  assign alu_in2   = s1_req_r.in2;
  assign alu_in1_b = s1_req_r.in1;
  assign alu_in2_b = s1_req_r.in2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU stand-in and an
// in-order scoreboard; expectations follow ALU_ARBITER_ROUND_ROBIN_EN.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  InstructionSetALU req_op [2];
  logic [31:0]      req_in1 [2];
  logic [31:0]      req_in2 [2];
  logic [31:0]      rsp_data;
  logic             rsp_flag;
  InstructionSetALU alu_op;
  logic [31:0]      alu_in1, alu_in2, alu_in1_b, alu_in2_b, alu_out;
  logic             alu_out_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        flag;
    int          acc_cyc;
  } exp_t;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_in1_b(alu_in1_b), .alu_in2_b(alu_in2_b),
    .alu_out(alu_out), .alu_out_b(alu_out_b)
  );

  function automatic logic [31:0] ref_data(InstructionSetALU op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_flag(InstructionSetALU op, logic [31:0] a, logic [31:0] b);
    return (op == ALU_SLT_B) && ($signed(a) < $signed(b));
  endfunction

  function automatic InstructionSetALU pick_op(int k);
    case (k)
      0: return ALU_ADD;
      1: return ALU_SUB;
      2: return ALU_AND;
      3: return ALU_OR;
      4: return ALU_XOR;
      5: return ALU_SLT;
      6: return ALU_SLTU;
      default: return ALU_SLT_B;
    endcase
  endfunction

  // Shared ALU outside the DUT: primary result from alu_in*, compare from alu_in*_b
  always_comb begin
    alu_out   = ref_data(alu_op, alu_in1, alu_in2);
    alu_out_b = ref_flag(alu_op, alu_in1_b, alu_in2_b);
  end

  task automatic idle_inputs();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int r = 0; r < 2; r++) begin
      req_op[r]  = ALU_NOP;
      req_in1[r] = 32'd0;
      req_in2[r] = 32'd0;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    req_op[0] = ALU_ADD; req_in1[0] = 32'd9; req_in2[0] = 32'd9;
    req_op[1] = ALU_OR;  req_in1[1] = 32'd3; req_in2[1] = 32'd4;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_cmp++; if (alu_op !== ALU_NOP) begin n_err++; $display("FAIL reset_alu_op: got %h want 00", alu_op); end
    n_cmp++; if ({rsp_data, rsp_flag} !== 33'd0) begin n_err++; $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_data, rsp_flag); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_cmp++; if ({alu_in1, alu_in2, alu_in1_b, alu_in2_b} !== 128'd0) begin n_err++; $display("FAIL reset_alu_in: got %h %h want 0", alu_in1, alu_in2); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL post_reset_rsp_valid: got %b want 00", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_op();
    apply_reset();
    req_valid = 2'b01; req_op[0] = ALU_ADD; req_in1[0] = 32'd5; req_in2[0] = 32'd7;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early: got %b want 00", rsp_valid); end
    n_cmp++; if ({alu_op, alu_in1, alu_in2} !== {ALU_ADD, 32'd5, 32'd7}) begin n_err++; $display("FAIL single_issue: got %h %0d %0d want 01 5 7", alu_op, alu_in1, alu_in2); end
    n_cmp++; if ({alu_in1_b, alu_in2_b} !== {32'd5, 32'd7}) begin n_err++; $display("FAIL single_issue_b: got %0d %0d want 5 7", alu_in1_b, alu_in2_b); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd12) begin n_err++; $display("FAIL single_rsp_data: got %0d want 12", rsp_data); end
    n_cmp++; if (rsp_flag !== 1'b0) begin n_err++; $display("FAIL single_rsp_flag: got %b want 0", rsp_flag); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_consumed: got %b want 00", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    apply_reset();
    req_valid = 2'b10; req_op[1] = ALU_SLT_B; req_in1[1] = 32'hFFFF_FFFF; req_in2[1] = 32'd1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL branch_ready: got %b want 10", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL branch_rsp_valid: got %b want 10", rsp_valid); end
    n_cmp++; if (rsp_flag !== 1'b1) begin n_err++; $display("FAIL branch_flag: got %b want 1", rsp_flag); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic [1:0] g_hist [8];
    logic [1:0] egr;
    apply_reset();
    req_op[0] = ALU_ADD; req_in1[0] = 32'd1;  req_in2[0] = 32'd2;
    req_op[1] = ALU_SUB; req_in1[1] = 32'd50; req_in2[1] = 32'd8;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (c < 6) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        egr = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
        egr = 2'b01;
`endif
      end else begin
        egr = 2'b00;
      end
      g_hist[c] = egr;
      n_cmp++; if (req_ready !== egr) begin n_err++; $display("FAIL contention_grant[%0d]: got %b want %b", c, req_ready, egr); end
      if (c >= 2) begin
        n_cmp++; if (rsp_valid !== g_hist[c-2]) begin n_err++; $display("FAIL contention_rsp_id[%0d]: got %b want %b", c, rsp_valid, g_hist[c-2]); end
        n_cmp++; if (rsp_data !== ((g_hist[c-2] == 2'b01) ? 32'd3 : 32'd42)) begin n_err++; $display("FAIL contention_rsp_data[%0d]: got %0d", c, rsp_data); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  e_rdy [9];
    logic [1:0]  e_rv  [9];
    logic [31:0] e_dat [9];
    logic [31:0] vals  [3];
    int k = 0;
    e_rdy = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    e_rv  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    e_dat = '{32'd0, 32'd0, 32'd7, 32'd7, 32'd7, 32'd7, 32'd17, 32'd27, 32'd0};
    vals  = '{32'd10, 32'd20, 32'd30};
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      req_valid  = (k < 3) ? 2'b01 : 2'b00;
      req_op[0]  = ALU_SUB;
      req_in1[0] = vals[(k < 3) ? k : 2];
      req_in2[0] = 32'd3;
      rsp_ready  = (c <= 4) ? 2'b00 : 2'b11;
      @(negedge clk);
      n_cmp++; if (req_ready !== e_rdy[c]) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want %b", c, req_ready, e_rdy[c]); end
      n_cmp++; if (rsp_valid !== e_rv[c]) begin n_err++; $display("FAIL bp_rsp_valid[%0d]: got %b want %b", c, rsp_valid, e_rv[c]); end
      if (e_rv[c] != 2'b00) begin
        n_cmp++; if (rsp_data !== e_dat[c]) begin n_err++; $display("FAIL bp_rsp_data[%0d]: got %0d want %0d", c, rsp_data, e_dat[c]); end
      end
      if (req_ready[0] && req_valid[0]) k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    int n_rsp = 0;
    apply_reset();
    req_valid = 2'b01; req_op[0] = ALU_XOR; req_in1[0] = 32'hF0; req_in2[0] = 32'h0F;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_accept: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (alu_op !== ALU_XOR) begin n_err++; $display("FAIL mid_inflight_op: got %h want 10", alu_op); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rsp_in_reset: got %b want 00", rsp_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 2'b11;
    req_op[0] = ALU_ADD; req_in1[0] = 32'd1; req_in2[0] = 32'd1;
    req_op[1] = ALU_ADD; req_in1[1] = 32'd2; req_in2[1] = 32'd2;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_data, rsp_flag} !== 35'd0) begin n_err++; $display("FAIL mid_after_rsp: got %b %h %b want 0", rsp_valid, rsp_data, rsp_flag); end
    n_cmp++; if ({alu_op, alu_in1, alu_in2} !== {ALU_NOP, 64'd0}) begin n_err++; $display("FAIL mid_after_alu: got %h %h %h want 0", alu_op, alu_in1, alu_in2); end
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_after_grant: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        n_rsp++;
        n_cmp++; if ({rsp_valid, rsp_data} !== {2'b01, 32'd2}) begin n_err++; $display("FAIL mid_next_rsp: got %b %h want 01 2", rsp_valid, rsp_data); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (n_rsp !== 1) begin n_err++; $display("FAIL mid_rsp_count: got %0d want 1", n_rsp); end
  endtask

  // Random traffic against an in-order, capacity-two occupancy model
  task automatic test_random(input int n);
    exp_t             q [$];
    exp_t             e;
    logic             pv [2];
    InstructionSetALU pop [2];
    logic [31:0]      pa [2];
    logic [31:0]      pb [2];
    logic             last = 1'b1;
    logic             vis, can, id;
    logic [1:0]       erv, egr, erdy;
    apply_reset();
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && $urandom_range(0, 99) < 60) begin
          pv[r]  = 1'b1;
          pop[r] = pick_op($urandom_range(0, 7));
          pa[r]  = $urandom();
          pb[r]  = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom();
        end
        req_valid[r] = pv[r];
        req_op[r]    = pv[r] ? pop[r] : ALU_NOP;
        req_in1[r]   = pa[r];
        req_in2[r]   = pb[r];
      end
      rsp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);
      vis = (q.size() > 0) && (q[0].acc_cyc + 2 <= c);
      erv = vis ? (2'b01 << q[0].id) : 2'b00;
      can = (q.size() < 2) || (vis && rsp_ready[q[0].id]);
      case (req_valid)
        2'b01: egr = 2'b01;
        2'b10: egr = 2'b10;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        2'b11: egr = (last == 1'b1) ? 2'b01 : 2'b10;
`else
        2'b11: egr = 2'b01;
`endif
        default: egr = 2'b00;
      endcase
      erdy = can ? egr : 2'b00;
      n_cmp++; if (req_ready !== erdy) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, erdy); end
      n_cmp++; if (rsp_valid !== erv) begin n_err++; $display("FAIL rand_rsp_valid[%0d]: got %b want %b", c, rsp_valid, erv); end
      if (vis) begin
        n_cmp++; if ({rsp_data, rsp_flag} !== {q[0].data, q[0].flag}) begin n_err++; $display("FAIL rand_rsp[%0d]: got %h/%b want %h/%b", c, rsp_data, rsp_flag, q[0].data, q[0].flag); end
      end
      @(posedge clk);
      if (vis && rsp_ready[q[0].id]) void'(q.pop_front());
      if (erdy != 2'b00) begin
        id        = erdy[1];
        e.id      = id;
        e.data    = ref_data(pop[id], pa[id], pb[id]);
        e.flag    = ref_flag(pop[id], pa[id], pb[id]);
        e.acc_cyc = c;
        q.push_back(e);
        pv[id] = 1'b0;
        last   = id;
      end
      #1;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_op();
    test_branch();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
